// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Imported by the loader top level and the word assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam logic [31:0] DEF_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/word_assembler.sv
// Shifts accepted bytes in MSB-first and flags each completed 32-bit word.
// The word output is combinational so the 4th byte is usable on its accept cycle.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        acc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sreg_q, sreg_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (acc_i) begin
      sreg_d = {sreg_q[15:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o       = {sreg_q, byte_i};
  assign word_valid_o = acc_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: length, big-endian payload words, XOR checksum.
// Writes the image into program memory and releases the CPU on a clean load.
module program_loader
  import loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS =
    DATA_WIDTH'(DEF_BASE_ADDRESS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [1:0]            err_code_o,
  output logic                  cpu_reset_o
);

  localparam int IW = $clog2(MEMORY_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         idx_inc;
  logic [7:0]            csum_q, csum_d;
  logic [1:0]            err_q, err_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  busy;
  logic                  acc;
  logic [31:0]           asm_word;
  logic                  asm_valid;
  logic [DATA_WIDTH-1:0] word_w;

  assign busy    = (state_q == LEN) || (state_q == DATA) ||
                   (state_q == CHECK);
  assign acc     = busy && byte_valid_i;
  assign word_w  = DATA_WIDTH'(asm_word);
  assign idx_inc = idx_q + IW'(1);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (!busy),
    .acc_i        (acc),
    .byte_i       (byte_i),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (acc && (state_q != CHECK))
      csum_d = csum_q ^ byte_i;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = LEN;
          count_d = '0;
          idx_d   = '0;
          csum_d  = '0;
          err_d   = ERR_NONE;
        end
      end
      LEN: begin
        if (asm_valid) begin
          count_d = IW'(word_w);
          if (word_w > DATA_WIDTH'(MEMORY_DEPTH)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else if (word_w == '0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_valid) begin
          we_d   = 1'b1;
          addr_d = BASE_ADDRESS +
                   {{(DATA_WIDTH-IW-2){1'b0}}, idx_q, 2'b00};
          data_d = word_w;
          idx_d  = idx_inc;
          if (idx_inc == count_q)
            state_d = CHECK;
        end
      end
      CHECK: begin
        if (acc) begin
          if (byte_i == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign byte_ready_o = busy;
  assign busy_o       = busy;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERROR);
  assign err_code_o   = err_q;
  assign cpu_reset_o  = (state_q != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader.
// Frames are built from the framing rules; writes are compared to a model.
module tb_program_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;
  logic        cpu_reset_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  fr_q[$];
  logic [31:0] pay_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  program_loader #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_code_o   (err_code_o),
    .cpu_reset_o  (cpu_reset_o)
  );

  always @(negedge clk) begin
    if (mem_we_o) begin
      wa_q.push_back(mem_addr_o);
      wd_q.push_back(mem_data_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Length, payload (from pay_q), then checksum unless the length is too big.
  task automatic make_frame(input int unsigned n, input bit corrupt);
    logic [7:0]  x;
    logic [31:0] w;
    logic [31:0] nn;
    fr_q.delete();
    nn = n;
    for (int i = 3; i >= 0; i--) fr_q.push_back(nn[i*8 +: 8]);
    if (n <= DEPTH) begin
      for (int k = 0; k < int'(n); k++) begin
        w = pay_q[k];
        for (int i = 3; i >= 0; i--) fr_q.push_back(w[i*8 +: 8]);
      end
      x = 8'h00;
      foreach (fr_q[i]) x = x ^ fr_q[i];
      if (corrupt) x = x ^ 8'h01;
      fr_q.push_back(x);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input bit bubbles,
                          input bit mid_start);
    int tries = 0;
    while (bubbles && ($urandom_range(0, 2) == 0)) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      start_i = mid_start && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start_i = mid_start && ($urandom_range(0, 3) == 0);
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!byte_ready_o) chk("ready_timeout", 32'(byte_ready_o), 32'd1);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int unsigned n,
                           input bit corrupt, input bit bubbles,
                           input bit mid_start);
    int nw;
    make_frame(n, corrupt);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    foreach (fr_q[i]) put_byte(fr_q[i], bubbles, mid_start);
    @(negedge clk);
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    if (n > DEPTH) begin
      chk({tag, "_error"}, 32'(error_o), 32'd1);
      chk({tag, "_code"}, 32'(err_code_o), 32'd1);
      chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    end else if (corrupt) begin
      chk({tag, "_error"}, 32'(error_o), 32'd1);
      chk({tag, "_code"}, 32'(err_code_o), 32'd2);
      chk({tag, "_cpurst"}, 32'(cpu_reset_o), 32'd1);
    end else begin
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_code"}, 32'(err_code_o), 32'd0);
      chk({tag, "_cpurst"}, 32'(cpu_reset_o), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    nw = (n > DEPTH) ? 0 : int'(n);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wa_q.size(); k++) begin
      chk({tag, "_addr"}, wa_q[k], BASE + 32'(4 * k));
      chk({tag, "_data"}, wd_q[k], pay_q[k]);
    end
  endtask

  task automatic rand_payload(input int unsigned n);
    pay_q.delete();
    for (int k = 0; k < int'(n); k++) pay_q.push_back($urandom());
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_cpurst", 32'(cpu_reset_o), 32'd1);

    pay_q.delete();
    pay_q.push_back(32'h2008_0005);
    pay_q.push_back(32'h2009_000A);
    run_frame("n2", 2, 1'b0, 1'b0, 1'b0);

    pay_q.delete();
    run_frame("n0", 0, 1'b0, 1'b0, 1'b0);

    pay_q.delete();
    run_frame("n257", 257, 1'b0, 1'b0, 1'b0);

    rand_payload(1);
    run_frame("badcs", 1, 1'b1, 1'b0, 1'b0);

    rand_payload(DEPTH);
    run_frame("nmax", DEPTH, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int unsigned n = $urandom_range(1, 9);
      rand_payload(n);
      run_frame("rnd", n, 1'b0, 1'b1, 1'b1);
    end

    rand_payload(1);
    make_frame(1, 1'b0);
    pulse_start();
    for (int i = 0; i < 6; i++) put_byte(fr_q[i], 1'b0, 1'b0);
    @(negedge clk);
    byte_valid_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_cpurst", 32'(cpu_reset_o), 32'd1);
    chk("arst_we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rand_payload(1);
    run_frame("after_rst", 1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader that writes the instruction image into the writable program memory before the MIPS core runs. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and assembles big-endian 32-bit words. It issues one write per word at consecutive byte addresses starting at `BASE_ADDRESS`, matching the fetch mapping `(addr - 0x400000) >> 2`. It holds the CPU in reset until a load completes cleanly.

## Interface
Parameters:
- `MEMORY_DEPTH`, 256: program memory depth in words; this is the maximum accepted word count.
- `DATA_WIDTH`, 32: instruction and address width.
- `BASE_ADDRESS`, 32'h400000: byte address of the first word written.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  begins a load; sampled in IDLE, DONE and ERROR only.
- `byte_i`  in  8  stream byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  loader accepts a byte; a transfer occurs when valid and ready are both 1.
- `mem_we_o`  out  1  one-cycle write strobe to program memory.
- `mem_addr_o`  out  DATA_WIDTH  byte address of the write.
- `mem_data_o`  out  DATA_WIDTH  instruction word.
- `busy_o`  out  1  a load is in progress.
- `done_o`  out  1  sticky flag: last load succeeded.
- `error_o`  out  1  sticky flag: last load failed.
- `err_code_o`  out  2  0 none, 1 length too large, 2 checksum mismatch.
- `cpu_reset_o`  out  1  held high except in DONE.

## Operation
- Frame format: 4 length bytes (word count N, big-endian), then 4·N payload bytes, then 1 checksum byte.
- Checksum: the XOR of all 4 + 4·N preceding bytes.
- Payload byte order: the first byte of each group of four is bits [31:24].
- FSM states and transitions:
  - IDLE, on `start_i`: go to LEN. Clear the word count, byte counter, write index and checksum.
  - LEN, after 4 bytes: if N > MEMORY_DEPTH, go to ERROR with code 1. If N == 0, go to CHECK. Otherwise go to DATA.
  - DATA, on each 4th byte: write word k to address BASE_ADDRESS + 4·k and increment k. When k reaches N, go to CHECK.
  - CHECK, on 1 byte: go to DONE if the byte equals the running XOR. Otherwise go to ERROR with code 2.
  - DONE and ERROR: hold. On `start_i`, go to LEN and clear both flags and `err_code_o`.
- `byte_ready_o` is 1 exactly in LEN, DATA and CHECK. Bytes presented in any other state are not consumed.
- `busy_o` is 1 exactly in LEN, DATA and CHECK.
- Memory writes are never rolled back. After an error the memory holds a partial image, but the CPU stays in reset.
- `start_i` during LEN, DATA or CHECK is ignored.
- The write index is `$clog2(MEMORY_DEPTH)+1` bits wide. It never exceeds N, which is at most MEMORY_DEPTH.
- Address arithmetic is done at DATA_WIDTH bits with no wrap check; N ≤ MEMORY_DEPTH bounds it.

## Timing
- Reset values:
  - `byte_ready_o`, `mem_we_o`, `busy_o`, `done_o` and `error_o` are 0.
  - `err_code_o` is 0; `mem_addr_o` and `mem_data_o` are 0.
  - `cpu_reset_o` is 1; the state is IDLE.
- Reset asserted mid-load: the state returns to IDLE immediately (asynchronously) and any pending write strobe is dropped.
- Write latency: `mem_we_o` is high for exactly one cycle, in the cycle after the 4th byte of a word is accepted. Address and data are registered and stable during that cycle.
- Throughput: one byte per cycle at full rate; the loader never deasserts ready mid-frame.
- A write strobe may overlap acceptance of the next word's first byte.
- A final-word write may overlap the CHECK byte; the state change to DONE does not cancel the pending strobe.
- State update: the state after the CHECK byte (DONE or ERROR) is visible in the following cycle.
  - `cpu_reset_o` falls in that same cycle on success.
  - `done_o`/`error_o` rise in that same cycle.
- ERROR with code 1 is entered in the cycle after the 4th length byte. No write has occurred at that point.
- Bubbles (`byte_valid_i` = 0) stall all counters; there is no timeout.

## Structure
- Package `loader_pkg` holds:
  - the FSM state enum (IDLE, LEN, DATA, CHECK, DONE, ERROR);
  - error-code constants ERR_NONE, ERR_LEN and ERR_CSUM;
  - the default `BASE_ADDRESS`.
- Sub-module `word_assembler`: shifts in bytes MSB-first and flags word_valid on every 4th accepted byte. It has a clear input driven from IDLE, DONE and ERROR.
- The top level holds the FSM, word count, write index, checksum register and write-port registers.

## Test plan
- N=2, payload 0x20080005 0x2009000A, correct checksum → writes at 0x400000 and 0x400004 with those data. Then `done_o`=1, `cpu_reset_o`=0, `err_code_o`=0.
- N=0, checksum byte 0x00 → no writes, `done_o`=1.
- N=257 with MEMORY_DEPTH=256 → `error_o`=1, `err_code_o`=1, no `mem_we_o` pulse, `byte_ready_o`=0.
- N=1 with a corrupted checksum (expected XOR ^ 0x01) → one write occurs, then `err_code_o`=2, `cpu_reset_o` stays 1.
- Random bubbles on `byte_valid_i` plus `start_i` pulses mid-frame → same writes as a gap-free run; the mid-frame `start_i` has no effect.
- `reset` asserted during DATA after 6 bytes, then a full valid N=1 load → first write goes to 0x400000 and the load finishes with `done_o`=1.
